bcd_to_bin: RTL and testbench

- Sequential converter that reads the packed multi-digit BCD result of the BCD adder chain and produces its binary value.
- Input is the digit vector plus the adder's final carry-out, treated as a leading thousands digit of 0 or 1.
- Converts one digit per clock, most-significant first (acc = acc*10 + digit).
- Uses a valid/ready handshake on both sides, so it sits between the BCD datapath and binary consumers (display, compare, storage).

---
 rtl/bcd_to_bin.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: serial BCD-to-binary converter, one digit per clock, MSD first.
// Ports: clk, rst (async high); in_valid/in_ready + bcd_in/carry_in in;
//        out_valid/out_ready + bin_out/err out (err = some nibble > 9).
module bcd_to_bin #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  carry_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [4*DIGITS-1:0]   shreg_q, shreg_d;
   logic [BIN_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  err_r_q, err_r_d;
   logic [BIN_W-1:0]      bin_q, bin_d;
   logic                  err_q, err_d;

   logic [3:0]            digit;
   logic [BIN_W-1:0]      acc_next;
   logic                  err_next;
   logic                  accept;

   // Current digit always sits in the top nibble; the register shifts left.
   assign digit    = shreg_q[4*DIGITS-1 -: 4];
   // acc*10 + digit without a multiplier; wraps mod 2^BIN_W.
   assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
   assign err_next = err_r_q | (digit > 4'd9);
   assign accept   = in_valid && (state_q == IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)        state_d = CONV;
         CONV:    if (idx_q == '0)     state_d = DONE;
         DONE:    if (out_ready)       state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath next values
   always_comb begin
      shreg_d = shreg_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      err_r_d = err_r_q;
      bin_d   = bin_q;
      err_d   = err_q;
      if (accept) begin
         shreg_d = bcd_in;
         acc_d   = BIN_W'(carry_in);
         idx_d   = IDX_W'(DIGITS - 1);
         err_r_d = 1'b0;
      end else if (state_q == CONV) begin
         shreg_d = shreg_q << 4;
         acc_d   = acc_next;
         err_r_d = err_next;
         idx_d   = idx_q - 1'b1;
         if (idx_q == '0) begin
            bin_d = acc_next;
            err_d = err_next;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         err_r_q <= 1'b0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         err_r_q <= err_r_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
      end
   end

   assign bin_out = bin_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin: directed scenarios plus randomized traffic
// checked against a place-value reference model.
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] bcd_in;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] bin_out;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bcd_to_bin #(.DIGITS(3), .BIN_W(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .err       (err)
   );

   // Place-value reference: carry*1000 + sum(d_k * 10^k), reduced mod 2^11.
   function automatic void model(input logic [11:0] b, input logic c,
                                 output logic [10:0] v, output logic e);
      int sum;
      int w;
      logic [11:0] t;
      t   = b;
      sum = c ? 1000 : 0;
      w   = 1;
      e   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sum += int'(t[4*k +: 4]) * w;
         if (t[4*k +: 4] > 4'd9) e = 1'b1;
         w *= 10;
      end
      v = 11'(sum % 2048);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one input and return 1ns after the accept edge.
   task automatic send(input logic [11:0] b, input logic c);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
      end
      bcd_in   = b;
      carry_in = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      bcd_in = '0;
      carry_in = 1'b0;
      tick();
      tick();
      checks += 4;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %0b required 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid: got %0b required 0", out_valid);
      end
      if (bin_out !== 11'd0) begin
         failures++;
         $display("FAIL reset_bin: got %0d required 0", bin_out);
      end
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err: got %0b required 0", err);
      end
      rst = 1'b0;
      tick();
   endtask

   // Convert one value with full latency/result checks.
   task automatic test_value(input string nm, input logic [11:0] b,
                             input logic c, input logic scramble);
      int cyc;
      logic [10:0] ev;
      logic ee;
      model(b, c, ev, ee);
      send(b, c);
      if (scramble) begin
         bcd_in   = 12'h999;
         carry_in = 1'b1;
      end
      wait_out(cyc);
      checks += 3;
      if (cyc !== 3) begin
         failures++;
         $display("FAIL %s_latency: got %0d cycles required 3", nm, cyc);
      end
      if (bin_out !== ev) begin
         failures++;
         $display("FAIL %s_bin: got %0d required %0d", nm, bin_out, ev);
      end
      if (err !== ee) begin
         failures++;
         $display("FAIL %s_err: got %0b required %0b", nm, err, ee);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int cyc;
      send(12'h450, 1'b0);
      wait_out(cyc);
      checks++;
      if (cyc !== 3) begin
         failures++;
         $display("FAIL bp_latency: got %0d required 3", cyc);
      end
      bcd_in   = 12'h111;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 3;
         if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold_valid: got %0b required 1", out_valid);
         end
         if (bin_out !== 11'd450) begin
            failures++;
            $display("FAIL bp_hold_bin: got %0d required 450", bin_out);
         end
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready: got %0b required 0", in_ready);
         end
      end
      in_valid = 1'b0;
      consume();
      checks += 3;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release_valid: got %0b required 0", out_valid);
      end
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_ready: got %0b required 1", in_ready);
      end
      if (bin_out !== 11'd450) begin
         failures++;
         $display("FAIL bp_keep_bin: got %0d required 450", bin_out);
      end
      test_value("bp_next", 12'h001, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      logic saw;
      send(12'h777, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      checks += 4;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_in_ready: got %0b required 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_out_valid: got %0b required 0", out_valid);
      end
      if (bin_out !== 11'd0) begin
         failures++;
         $display("FAIL abort_bin: got %0d required 0", bin_out);
      end
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL abort_err: got %0b required 0", err);
      end
      saw = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (out_valid) saw = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_valid: got %0b required 0", saw);
      end
      test_value("abort_next", 12'h042, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [11:0] b;
      logic c;
      int cyc;
      logic [10:0] ev;
      logic ee;
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 3; k++)
            b[4*k +: 4] = ($urandom_range(0, 7) == 0) ?
                          4'($urandom_range(10, 15)) :
                          4'($urandom_range(0, 9));
         c = 1'($urandom_range(0, 1));
         model(b, c, ev, ee);
         send(b, c);
         bcd_in   = 12'($urandom);
         carry_in = 1'($urandom);
         wait_out(cyc);
         for (int d = $urandom_range(0, 3); d > 0; d--) tick();
         checks += 3;
         if (cyc !== 3) begin
            failures++;
            $display("FAIL rand_latency: got %0d required 3", cyc);
         end
         if (bin_out !== ev) begin
            failures++;
            $display("FAIL rand_bin: in=%h c=%0b got %0d required %0d",
                     b, c, bin_out, ev);
         end
         if (err !== ee) begin
            failures++;
            $display("FAIL rand_err: in=%h got %0b required %0b",
                     b, err, ee);
         end
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_value("zero", 12'h000, 1'b0, 1'b0);
      test_value("basic", 12'h123, 1'b0, 1'b1);
      test_value("max", 12'h999, 1'b1, 1'b0);
      test_backpressure();
      test_value("bad", 12'h1A5, 1'b0, 1'b0);
      test_value("clean", 12'h010, 1'b0, 1'b0);
      test_value("wrap", 12'hFFF, 1'b1, 1'b0);
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
